// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing controller for a shift-add multiplier datapath
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             p0,
  input  logic             result_ack,
  output logic             load,
  output logic             add,
  output logic             write,
  output logic             sr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] TEST  = 3'd2;
  localparam logic [2:0] ADD   = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  logic [2:0] state, state_nxt;
  logic       last;
  assign last = iter == CNT_W'(WIDTH - 1);
  // next-state selection; start and result_ack only matter in IDLE/DONE, p0 only in TEST
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = TEST;
      TEST:    state_nxt = p0 ? ADD : SHIFT;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = last ? DONE : TEST;
      DONE:    state_nxt = !result_ack ? DONE : (start ? LOAD : IDLE);
      default: state_nxt = IDLE;
    endcase
  end
  // state register and iteration counter, cleared on entry to LOAD so iter reads 0 while loading
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == LOAD) iter <= '0;
      else if (state == SHIFT && !last) iter <= iter + 1'b1;
    end
  end
  assign load  = state == LOAD;
  assign add   = state == ADD;
  assign write = state == ADD;
  assign sr    = state == SHIFT;
  assign done  = state == DONE;
  assign busy  = !(state == IDLE || state == DONE);
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed self-checking bench for mult_seq_ctrl at WIDTH=4 and WIDTH=32
module tb_mult_seq_ctrl;
  logic       clk = 0;
  logic       reset = 1;
  logic       start4 = 0, ack4 = 0, p04;
  logic       load4, add4, write4, sr4, busy4, done4;
  logic [5:0] iter4;
  logic       start32 = 0, ack32 = 0;
  logic       load32, add32, write32, sr32, busy32, done32;
  logic [5:0] iter32;
  logic [3:0] mval = 0, mreg = 0;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(4), .CNT_W(6)) u4 (
    .clk(clk), .reset(reset), .start(start4), .p0(p04), .result_ack(ack4),
    .load(load4), .add(add4), .write(write4), .sr(sr4), .busy(busy4), .done(done4), .iter(iter4)
  );

  mult_seq_ctrl #(.WIDTH(32), .CNT_W(6)) u32 (
    .clk(clk), .reset(reset), .start(start32), .p0(1'b1), .result_ack(ack32),
    .load(load32), .add(add32), .write(write32), .sr(sr32), .busy(busy32), .done(done32), .iter(iter32)
  );

  // tiny datapath model: multiplier register loaded on load, shifted right on sr
  always @(posedge clk) begin
    if (load4) mreg <= mval;
    else if (sr4) mreg <= mreg >> 1;
  end
  assign p04 = mreg[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [3:0] mult, input int pulse_at, output string seq,
                      output string its, output int edges, output int viol);
    mval = mult;
    start4 = 1;
    tick();
    start4 = 0;
    edges = 1;
    seq = "";
    its = "";
    viol = 0;
    while (!done4 && edges < 200) begin
      if (load4) seq = {seq, "L"};
      if (add4) seq = {seq, "A"};
      if (sr4) begin
        seq = {seq, "S"};
        its = {its, $sformatf("%0d", iter4)};
      end
      if ((int'(load4) + int'(add4) + int'(sr4)) > 1 || add4 !== write4 || busy4 !== 1'b1) viol++;
      start4 = (edges == pulse_at);
      tick();
      edges++;
    end
    start4 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    checks++;
    if ({load4, add4, write4, sr4, busy4, done4} !== 6'b0 || iter4 !== 6'd0) begin
      errors++;
      $display("FAIL reset_w4: outs=%b iter=%0d, want outs=000000 iter=0",
               {load4, add4, write4, sr4, busy4, done4}, iter4);
    end
    checks++;
    if ({load32, add32, write32, sr32, busy32, done32} !== 6'b0 || iter32 !== 6'd0) begin
      errors++;
      $display("FAIL reset_w32: outs=%b iter=%0d, want outs=000000 iter=0",
               {load32, add32, write32, sr32, busy32, done32}, iter32);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_basic();
    string seq, its;
    int edges, viol;
    run4(4'b1011, -1, seq, its, edges, viol);
    checks++;
    if (seq != "LASASSAS") begin errors++; $display("FAIL basic_seq: got %s want LASASSAS", seq); end
    checks++;
    if (edges !== 13) begin errors++; $display("FAIL basic_latency: got %0d want 13", edges); end
    checks++;
    if (its != "0123") begin errors++; $display("FAIL basic_iter: got %s want 0123", its); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL basic_exclusive: violations=%0d want 0", viol); end
    checks++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || iter4 !== 6'd3) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b iter=%0d want 1 0 3", done4, busy4, iter4);
    end
  endtask

  task automatic test_handshake();
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done4 !== 1'b1 || {load4, add4, write4, sr4, busy4} !== 5'b0 || iter4 !== 6'd3) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold_done: bad cycles=%0d want 0", bad); end
    start4 = 1;
    tick();
    start4 = 0;
    checks++;
    if (done4 !== 1'b1 || load4 !== 1'b0) begin
      errors++;
      $display("FAIL start_no_ack: done=%b load=%b want 1 0", done4, load4);
    end
    ack4 = 1;
    tick();
    ack4 = 0;
    checks++;
    if ({load4, add4, write4, sr4, busy4, done4} !== 6'b0) begin
      errors++;
      $display("FAIL ack_idle: outs=%b want 000000", {load4, add4, write4, sr4, busy4, done4});
    end
    tick();
    checks++;
    if ({load4, busy4, done4} !== 3'b0) begin
      errors++;
      $display("FAIL idle_stay: outs=%b want 000", {load4, busy4, done4});
    end
  endtask

  task automatic test_zero();
    string seq, its;
    int edges, viol;
    run4(4'b0000, 4, seq, its, edges, viol);
    checks++;
    if (seq != "LSSSS") begin errors++; $display("FAIL zero_seq: got %s want LSSSS", seq); end
    checks++;
    if (edges !== 10) begin errors++; $display("FAIL zero_latency: got %0d want 10", edges); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL zero_exclusive: violations=%0d want 0", viol); end
    ack4 = 1;
    tick();
    ack4 = 0;
  endtask

  task automatic test_mid_reset();
    string seq, its;
    int edges, viol;
    mval = 4'b1011;
    start4 = 1;
    tick();
    start4 = 0;
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({load4, add4, write4, sr4, busy4, done4} !== 6'b0 || iter4 !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset: outs=%b iter=%0d want 000000 0",
               {load4, add4, write4, sr4, busy4, done4}, iter4);
    end
    tick();
    run4(4'b1011, -1, seq, its, edges, viol);
    checks++;
    if (seq != "LASASSAS" || edges !== 13) begin
      errors++;
      $display("FAIL after_reset_run: seq=%s edges=%0d want LASASSAS 13", seq, edges);
    end
  endtask

  task automatic test_back_to_back();
    string seq, its;
    int edges, viol;
    run4(4'b0110, -1, seq, its, edges, viol);
    checks++;
    if (seq != "LSASASS" || edges !== 12) begin
      errors++;
      $display("FAIL b2b_first: seq=%s edges=%0d want LSASASS 12", seq, edges);
    end
    mval = 4'b1011;
    ack4 = 1;
    start4 = 1;
    tick();
    ack4 = 0;
    start4 = 0;
    checks++;
    if (load4 !== 1'b1 || iter4 !== 6'd0 || done4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load: load=%b iter=%0d done=%b busy=%b want 1 0 0 1", load4, iter4, done4, busy4);
    end
    edges = 1;
    while (!done4 && edges < 200) begin
      tick();
      edges++;
    end
    checks++;
    if (edges !== 13) begin errors++; $display("FAIL b2b_latency: got %0d want 13", edges); end
    ack4 = 1;
    tick();
    ack4 = 0;
  endtask

  task automatic test_ones32();
    int edges = 1, adds = 0, srs = 0, busy_lo = 0, mism = 0;
    start32 = 1;
    tick();
    start32 = 0;
    while (!done32 && edges < 400) begin
      if (add32) adds++;
      if (sr32) srs++;
      if (!busy32) busy_lo++;
      if (add32 !== write32) mism++;
      tick();
      edges++;
    end
    checks++;
    if (edges !== 98) begin errors++; $display("FAIL ones32_latency: got %0d want 98", edges); end
    checks++;
    if (adds !== 32 || srs !== 32 || mism !== 0) begin
      errors++;
      $display("FAIL ones32_counts: add=%0d sr=%0d mism=%0d want 32 32 0", adds, srs, mism);
    end
    checks++;
    if (busy_lo !== 0 || iter32 !== 6'd31) begin
      errors++;
      $display("FAIL ones32_busy_iter: busy_low=%0d iter=%0d want 0 31", busy_lo, iter32);
    end
    ack32 = 1;
    tick();
    ack32 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_handshake();
    test_zero();
    test_mid_reset();
    ack4 = 1;
    tick();
    ack4 = 0;
    test_back_to_back();
    test_ones32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencing controller for the team's shift-add multiplier datapath (product/multiplier register, adder, right shifter).
- Runs one WIDTH-bit multiply per start request. Issues load/add/write/shift strobes and counts iterations internally.
- Reports completion through a done/ack handshake.
- Sits between the CPU-side request logic and the multiplier datapath. Contains no arithmetic of its own.

Parameters:
- WIDTH, 32, number of multiplier bits, which equals the number of iterations; legal range 2..64.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new multiply; sampled only in IDLE or DONE.
- p0  input  1  LSB of the datapath product/multiplier register.
- result_ack  input  1  consumer has taken the result; sampled only in DONE.
- load  output  1  datapath loads operands and clears the product high half.
- add  output  1  datapath selects adder output (multiplicand + product high half).
- write  output  1  datapath writes the adder result into the product high half.
- sr  output  1  datapath shifts the product register right by 1.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  result valid; held until acknowledged.
- iter  output  CNT_W  current iteration index, 0..WIDTH-1.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous, active-high.
- Reset values: state=IDLE, iter=0; load, add, write, sr, busy and done all 0.
- Reset asserted mid-operation aborts within one edge. No strobe is asserted in the cycle after reset.
- Moore FSM. Outputs are decoded only from registered state, never from inputs. States and transitions:
  - IDLE: all strobes 0. start=1 -> LOAD.
  - LOAD: load=1, iter<=0 -> TEST.
  - TEST: no strobes. p0=1 -> ADD; p0=0 -> SHIFT. p0 is sampled only in this state.
  - ADD: add=1, write=1 -> SHIFT.
  - SHIFT: sr=1. If iter==WIDTH-1 -> DONE; otherwise iter<=iter+1 -> TEST.
  - DONE: done=1, busy=0.
    - result_ack=0 -> stay in DONE.
    - result_ack=1, start=0 -> IDLE.
    - result_ack=1, start=1 -> LOAD (back-to-back operation, no IDLE cycle).
    - start=1, result_ack=0 -> ignored.
- start while busy: ignored, not queued.
- At most one of load, sr, and the add/write pair is asserted in any cycle. add and write are always asserted together.
- Latency:
  - Let k be the popcount of the multiplier bits seen as p0 in TEST.
  - done rises 2 + 2*WIDTH + k rising edges after the edge that samples start.
  - Best case (k=0) is 2+2W; worst case (k=W) is 2+3W.
- iter holds its final value WIDTH-1 in DONE and returns to 0 only on LOAD or reset.
- p0 toggling in states other than TEST has no effect.

Test Plan:
- Reset mid-operation: WIDTH=4, start, then reset in the third cycle of the operation -> next cycle state=IDLE, all outputs 0, iter=0. A later start runs normally.
- Basic run: WIDTH=4, multiplier 4'b1011 (p0 sequence 1,1,0,1) -> strobe order load, add/write, sr, add/write, sr, sr, add/write, sr. done rises 13 edges after start; iter reads 0,1,2,3.
- Zero multiplier: WIDTH=4, p0 always 0 -> add and write never asserted, exactly 4 sr pulses, done after 10 edges.
- All-ones multiplier at default WIDTH=32: p0 always 1 -> 32 add/write pulses and 32 sr pulses, done after 98 edges, busy high throughout.
- Handshake:
  - Hold result_ack=0 for 5 cycles in DONE -> done held, no strobes.
  - start pulsed while busy, or in DONE without ack -> no effect.
  - ack with start=0 -> IDLE.
- Back-to-back: in DONE assert result_ack=1 and start=1 in the same cycle -> next state LOAD, load=1 next cycle, iter=0.
